// File: rtl/gyro_pkg.sv
// Shared types and helpers for the gyro angle tracker.
package gyro_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_CAL    = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  // Signed add clamped to the range of a w-bit signed value (w <= 63).
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned w);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/gyro_axis_integ.sv
// One axis: bias calibration accumulator, deadband and saturating angle integrator.
module gyro_axis_integ
  import gyro_pkg::*;
#(
  parameter int unsigned CAL_LOG2 = 6,
  parameter int unsigned DEADBAND = 16,
  parameter int unsigned ANGLE_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [DATA_W-1:0]  data,
  input  logic                      tick,
  input  logic                      cal_en,
  input  logic                      cal_done,
  input  logic                      clr_angle,
  input  logic                      clr_all,
  output logic signed [ANGLE_W-1:0] angle,
  output logic signed [DATA_W-1:0]  bias
);

  localparam int unsigned ACC_W = DATA_W + CAL_LOG2;
  localparam int unsigned C_W   = DATA_W + 1;
  localparam logic signed [C_W-1:0] DB_POS = C_W'(DEADBAND);
  localparam logic signed [C_W-1:0] DB_NEG = -DB_POS;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [C_W-1:0]   diff;
  logic signed [C_W-1:0]   corr;

  assign acc_sum = acc + ACC_W'(data);

  // Bias-corrected rate with small values squashed to zero.
  always_comb begin
    diff = C_W'(data) - C_W'(bias);
    corr = diff;
    if (diff >= DB_NEG && diff <= DB_POS) corr = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr_all || cal_done) begin
      acc <= '0;
    end else if (cal_en) begin
      acc <= acc_sum;
    end
  end

  // The final sample is folded in directly so bias lands one cycle after the last cal tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bias <= '0;
    end else if (clr_all) begin
      bias <= '0;
    end else if (cal_done) begin
      bias <= DATA_W'(acc_sum >>> CAL_LOG2);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      angle <= '0;
    end else if (clr_angle) begin
      angle <= '0;
    end else if (tick) begin
      angle <= ANGLE_W'(sat_add(64'(angle), 64'(corr), ANGLE_W));
    end
  end

endmodule

// File: rtl/gyro_angle_tracker.sv
// Gyro rate integrator: tick prescaler, warm-up/calibration sequencing and three axis integrators.
module gyro_angle_tracker
  import gyro_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned SAMPLE_HZ = 100,
  parameter int unsigned WARMUP    = 50,
  parameter int unsigned CAL_LOG2  = 6,
  parameter int unsigned DEADBAND  = 16,
  parameter int unsigned ANGLE_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [DATA_W-1:0]  data_x,
  input  logic signed [DATA_W-1:0]  data_y,
  input  logic signed [DATA_W-1:0]  data_z,
  input  logic                      zero,
  input  logic                      recal,
  output logic                      ready,
  output logic                      angle_vld,
  output logic signed [ANGLE_W-1:0] angle_x,
  output logic signed [ANGLE_W-1:0] angle_y,
  output logic signed [ANGLE_W-1:0] angle_z,
  output logic signed [DATA_W-1:0]  bias_x,
  output logic signed [DATA_W-1:0]  bias_y,
  output logic signed [DATA_W-1:0]  bias_z
);

  localparam int unsigned TICK_DIV = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned TICK_W   = $clog2(TICK_DIV);
  localparam int unsigned WARM_W   = (WARMUP < 2) ? 1 : $clog2(WARMUP);
  localparam int unsigned CAL_CW   = (CAL_LOG2 < 1) ? 1 : CAL_LOG2;
  localparam int unsigned CAL_N    = 1 << CAL_LOG2;

  state_t              state;
  state_t              state_next;
  logic [TICK_W-1:0]   tick_cnt;
  logic [WARM_W-1:0]   warm_cnt;
  logic [CAL_CW-1:0]   cal_cnt;
  logic                tick;
  logic                warm_last;
  logic                cal_last;
  logic                cal_en;
  logic                cal_done;
  logic                run_tick;
  logic                clr_angle;
  logic                clr_all;

  assign tick      = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign warm_last = (warm_cnt == WARM_W'(WARMUP - 1));
  assign cal_last  = (cal_cnt == CAL_CW'(CAL_N - 1));

  // Free-running sample prescaler, independent of zero/recal.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_WARMUP;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (recal) begin
      state_next = ST_CAL;
    end else begin
      case (state)
        ST_WARMUP: if (WARMUP == 0 || (tick && warm_last)) state_next = ST_CAL;
        ST_CAL:    if (tick && cal_last) state_next = ST_RUN;
        ST_RUN:    state_next = ST_RUN;
        default:   state_next = ST_WARMUP;
      endcase
    end
  end

  always_comb begin
    cal_en    = 1'b0;
    cal_done  = 1'b0;
    run_tick  = 1'b0;
    clr_angle = 1'b0;
    clr_all   = 1'b0;
    if (recal) begin
      clr_all   = 1'b1;
      clr_angle = 1'b1;
    end else begin
      case (state)
        ST_CAL: begin
          cal_en   = tick;
          cal_done = tick && cal_last;
        end
        ST_RUN: begin
          clr_angle = zero;
          run_tick  = tick && !zero;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warm_cnt <= '0;
    end else if (state == ST_WARMUP && tick) begin
      warm_cnt <= warm_cnt + WARM_W'(1);
    end
  end

  // Wraps to zero naturally after the last calibration sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cal_cnt <= '0;
    end else if (clr_all) begin
      cal_cnt <= '0;
    end else if (cal_en) begin
      cal_cnt <= cal_cnt + CAL_CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready     <= 1'b0;
      angle_vld <= 1'b0;
    end else begin
      ready     <= (state_next == ST_RUN);
      angle_vld <= run_tick;
    end
  end

  gyro_axis_integ #(.CAL_LOG2(CAL_LOG2), .DEADBAND(DEADBAND), .ANGLE_W(ANGLE_W)) u_axis_x (
    .clk(clk), .rst(rst), .data(data_x), .tick(run_tick), .cal_en(cal_en),
    .cal_done(cal_done), .clr_angle(clr_angle), .clr_all(clr_all),
    .angle(angle_x), .bias(bias_x)
  );

  gyro_axis_integ #(.CAL_LOG2(CAL_LOG2), .DEADBAND(DEADBAND), .ANGLE_W(ANGLE_W)) u_axis_y (
    .clk(clk), .rst(rst), .data(data_y), .tick(run_tick), .cal_en(cal_en),
    .cal_done(cal_done), .clr_angle(clr_angle), .clr_all(clr_all),
    .angle(angle_y), .bias(bias_y)
  );

  gyro_axis_integ #(.CAL_LOG2(CAL_LOG2), .DEADBAND(DEADBAND), .ANGLE_W(ANGLE_W)) u_axis_z (
    .clk(clk), .rst(rst), .data(data_z), .tick(run_tick), .cal_en(cal_en),
    .cal_done(cal_done), .clr_angle(clr_angle), .clr_all(clr_all),
    .angle(angle_z), .bias(bias_z)
  );

endmodule
